mem_responder: RTL

Memory-side responder for the datapath's MAR/MDR memory interface. It accepts read and write requests from the CPU (address from MAR, write data from MDR), models a fixed-latency synchronous RAM, and returns read data on `Mdatain` with a one-cycle `done` pulse. It replaces the hand-driven `Mdatain` stimulus in datapath benches and is the memory that the future control unit sequences against.

---
 rtl/mem_responder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Fixed-latency synchronous RAM responder for the MAR/MDR memory port.
// Requests are latched in IDLE, serviced after LATENCY edges, then acknowledged with a single done pulse.
module mem_responder #(
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  output logic [31:0]       Mdatain,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              op_write_reg;
  logic [31:0]       mdatain_reg;
  logic              done_reg;
  logic              busy_reg;
  logic              err_reg;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       mem_q_reg;

  logic [ADDR_W-1:0] rd_addr;
  logic              accept;
  logic              conflict;
  logic              access;
  logic              in_range;

  assign accept   = (state_reg == IDLE) && (read ^ write);
  assign conflict = (state_reg == IDLE) && read && write;
  assign access   = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign in_range = {1'b0, addr_reg} < DEPTH_L;

  // Point the read port at the incoming address on the accept edge so the
  // registered RAM output is already valid when LATENCY is 1.
  assign rd_addr = (state_reg == IDLE) ? address : addr_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (conflict)
          state_next = RELEASE;
        else if (accept)
          state_next = BUSY;
      end
      BUSY: begin
        if (cnt_reg == 4'd0)
          state_next = DONE;
      end
      DONE:    state_next = RELEASE;
      RELEASE: begin
        if (!read && !write)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM array: not reset, single write port, registered read.
  always_ff @(posedge clock) begin
    if (access && op_write_reg && in_range && !clear)
      mem[addr_reg[IDX_W-1:0]] <= wdata_reg;
    mem_q_reg <= mem[rd_addr[IDX_W-1:0]];
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      wdata_reg    <= 32'd0;
      op_write_reg <= 1'b0;
      mdatain_reg  <= 32'd0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_next == DONE);
      busy_reg  <= (state_next == BUSY) || (state_next == DONE);

      if (accept) begin
        addr_reg     <= address;
        wdata_reg    <= wdata;
        op_write_reg <= write;
        cnt_reg      <= CNT_LOAD;
      end else if ((state_reg == BUSY) && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end

      if (conflict)
        err_reg <= 1'b1;

      if (access) begin
        if (!in_range)
          err_reg <= 1'b1;
        if (!op_write_reg)
          mdatain_reg <= in_range ? mem_q_reg : 32'd0;
      end
    end
  end

  assign Mdatain = mdatain_reg;
  assign done    = done_reg;
  assign busy    = busy_reg;
  assign err     = err_reg;

endmodule
